mac_aging_table: RTL and testbench
==================================

// Module: mac_aging_table
// PURPOSE
//  Learned-address store that sits directly downstream of the MAC learning
//  arbiter. It takes (SA slot, ingress port) learn writes and answers
//  destination lookups with the egress port.
//  Every entry carries an age that is reloaded on each learn. The age is
//  decremented once per one-second tick and the entry is invalidated when the
//  age expires.
// PARAMETERS
//  pSLOTS        16384  table entries; the address width is $clog2(pSLOTS)
//  pADRESS       2      port-number width
//  pTIME         9      age-field width
//  pAGE_INIT     300    age loaded on every learn (ticks of life)
//  pONE_SECOND   32768  iclk cycles per aging tick; must be > pSLOTS+2 (elaboration check)
// PORTS
//  iclk           in   1               clock
//  irst_n         in   1               asynchronous active-low reset
//  i_write_en     in   1               learn strobe, one entry per cycle
//  i_write_sa     in   $clog2(pSLOTS)  slot to learn
//  i_write_port   in   pADRESS         ingress port for that slot
//  i_lookup_en    in   1               lookup strobe
//  i_lookup_da    in   $clog2(pSLOTS)  slot to look up
//  o_lookup_valid out  1               lookup result valid (1 cycle after i_lookup_en)
//  o_hit          out  1               entry valid at lookup
//  o_port_num     out  pADRESS         stored port; 0 on miss
//  o_ready        out  1               table initialised and accepting learns
//  o_sweep_busy   out  1               aging sweep in progress
//  o_entry_count  out  $clog2(pSLOTS)+1  valid entries (only with MAC_TABLE_STATS_EN)
// BEHAVIOUR
//  - Clocking/reset: one clock, iclk; irst_n is asynchronous and active-low.
//  - Reset values: all outputs are 0, FSM=CLEAR, tick counter=0, pending-tick flag=0.
//  - Entry format: {valid, port[pADRESS], age[pTIME]}. The storage array itself is not reset.
//  - FSM CLEAR: writes valid=0 to slot 0..pSLOTS-1, one slot per cycle, with o_ready=0.
//    It then goes to IDLE and o_ready rises; the tick counter starts from 0.
//  - During CLEAR:
//    - learns are dropped;
//    - lookups return o_lookup_valid=1, o_hit=0.
//  - Reset asserted mid-operation re-enters CLEAR.
//  - Tick: the counter runs from 0 to pONE_SECOND-1 and then wraps; a 1-cycle tick fires on the wrap.
//    - A tick in IDLE moves the FSM to SWEEP.
//    - A tick during SWEEP sets the pending flag; multiple pending ticks collapse to one.
//  - SWEEP: the sweep pointer starts at 0 and does a 2-stage read-modify-write per slot.
//    - valid && age==1  -> write valid=0, age=0.
//    - valid && age>1   -> age-1.
//    - !valid           -> no write.
//    - After slot pSLOTS-1: go to SWEEP again if the pending flag is set (flag cleared), else go to IDLE.
//    - o_sweep_busy=1 while in SWEEP.
//  - Learn (o_ready=1): writes {1, i_write_port, pAGE_INIT}; the entry is visible to lookups next cycle.
//  - Learn priority over sweep:
//    - The sweep pointer and sweep write stage stall in any cycle with i_write_en=1.
//    - A learn to the slot held in the sweep write stage cancels that sweep write (the fresh age wins).
//  - Lookup: registered, latency 1, read-before-write.
//    - A lookup to a slot being learned in the same cycle returns the old contents.
//  - Port-number width: i_write_port is truncated to pADRESS bits. The age is never decremented below 0.
// CONFIGURATION
//  - MAC_TABLE_STATS_EN defined: o_entry_count exists.
//    - +1 on a learn into an invalid slot; -1 on an age-out.
//    - Both in one cycle (different slots) -> net 0.
//    - Re-learning a valid slot leaves the count unchanged.
//    - CLEAR forces the count to 0.
//  - MAC_TABLE_STATS_EN undefined: the port and its counter logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package mac_pkg holds:
//    - pSLOTS, pADRESS, pTIME, pAGE_INIT, pONE_SECOND;
//    - typedef mac_entry_t {valid, port, age};
//    - enum mac_tbl_state_t {CLEAR, IDLE, SWEEP}.
//  - Sub-module mac_second_timer: the tick counter/generator with iclk, irst_n, i_run, o_tick.
//  - The FSM, RMW pipeline and storage array stay in mac_aging_table.
// TESTING  (sim params: pSLOTS=16, pONE_SECOND=64, pAGE_INIT=3, pTIME=9)
//  1. Release reset -> o_ready=0 for 16 cycles then 1; a lookup at da=5 during CLEAR -> o_hit=0.
//  2. Learn sa=5 port=2, then lookup da=5 the next cycle -> o_lookup_valid=1, o_hit=1, o_port_num=2.
//  3. Learn sa=7 and never refresh -> hit after ticks 1 and 2, miss after tick 3.
//     With MAC_TABLE_STATS_EN, o_entry_count goes 1 -> 0.
//  4. Learn sa=9 in the cycle the sweep write stage holds slot 9 with age 1 -> entry stays valid with age 3.
//     The sweep pointer stalls one cycle.
//  5. Learn sa=3 port=1 and lookup da=3 in the same cycle -> miss (old contents); lookup again -> hit, port 1.
//  6. Assert irst_n=0 mid-SWEEP for 1 cycle -> outputs 0, CLEAR reruns, all entries miss afterwards.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC aging table: default sizing, the stored
// entry layout and the table controller state encoding.
package mac_pkg;

    localparam int pSLOTS      = 16384;
    localparam int pADRESS     = 2;
    localparam int pTIME       = 9;
    localparam int pAGE_INIT   = 300;
    localparam int pONE_SECOND = 32768;

    // One stored entry: valid flag, learned port, remaining life in ticks.
    typedef struct packed {
        logic               valid;
        logic [pADRESS-1:0] port;
        logic [pTIME-1:0]   age;
    } mac_entry_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        SWEEP = 2'd2
    } mac_tbl_state_t;

endpackage

// File: rtl/mac_second_timer.sv
// Aging tick generator: counts iclk cycles while i_run is high and pulses
// o_tick for one cycle each time the count wraps from pONE_SECOND-1 to 0.
module mac_second_timer #(
    parameter int pONE_SECOND = 32768
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic i_run,
    output logic o_tick
);

    localparam int CW = (pONE_SECOND > 1) ? $clog2(pONE_SECOND) : 1;

    logic [CW-1:0] count;

    // Free-running period counter; held at zero while the table is clearing.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            count  <= '0;
            o_tick <= 1'b0;
        end else if (!i_run) begin
            count  <= '0;
            o_tick <= 1'b0;
        end else if (count == CW'(pONE_SECOND - 1)) begin
            count  <= '0;
            o_tick <= 1'b1;
        end else begin
            count  <= count + 1'b1;
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/mac_aging_table.sv
// Learned-address table with per-entry aging.
// Learns write {valid, port, pAGE_INIT}; lookups are registered (latency 1,
// read-before-write). A one-second tick launches a sweep that walks every
// slot with a 2-stage read-modify-write, decrementing ages and invalidating
// expired entries. Learns always win: any learn stalls the sweep for that
// cycle, and a learn to the slot sitting in the sweep write stage drops that
// stale sweep write.
// Optional feature macro: MAC_TABLE_STATS_EN adds o_entry_count.
// Handshake: strobes only, no back-pressure. i_write_en/i_lookup_en are
// single-cycle requests; o_lookup_valid pulses exactly one cycle after each
// i_lookup_en, and learns issued while o_ready=0 are discarded.
module mac_aging_table
    import mac_pkg::*;
#(
    parameter int pSLOTS      = mac_pkg::pSLOTS,
    parameter int pAGE_INIT   = mac_pkg::pAGE_INIT,
    parameter int pONE_SECOND = mac_pkg::pONE_SECOND
) (
    input  logic                      iclk,
    input  logic                      irst_n,
    input  logic                      i_write_en,
    input  logic [$clog2(pSLOTS)-1:0] i_write_sa,
    input  logic [pADRESS-1:0]        i_write_port,
    input  logic                      i_lookup_en,
    input  logic [$clog2(pSLOTS)-1:0] i_lookup_da,
    output logic                      o_lookup_valid,
    output logic                      o_hit,
    output logic [pADRESS-1:0]        o_port_num,
    output logic                      o_ready,
    output logic                      o_sweep_busy,
`ifdef MAC_TABLE_STATS_EN
    output logic [$clog2(pSLOTS):0]   o_entry_count,
`endif
    output mac_tbl_state_t            o_state
);

    localparam int AW = $clog2(pSLOTS);

    // A sweep needs pSLOTS+2 cycles; a shorter period would starve it forever.
    if (pONE_SECOND <= pSLOTS + 2) begin : g_bad_period
        $error("mac_aging_table: pONE_SECOND must exceed pSLOTS+2");
    end

    mac_entry_t     mem [pSLOTS];
    mac_tbl_state_t state;

    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] sweep_ptr;
    logic [AW-1:0] s1_addr;
    mac_entry_t    s1_data;
    logic          s1_valid;
    logic          rd_done;
    logic          pending;
    logic          tick;

    logic          learn;
    logic          sweep_adv;
    logic          sw_we;
    mac_entry_t    sw_data;
    logic          ageout;

    mac_second_timer #(
        .pONE_SECOND(pONE_SECOND)
    ) u_timer (
        .iclk  (iclk),
        .irst_n(irst_n),
        .i_run (state != CLEAR),
        .o_tick(tick)
    );

    assign learn     = i_write_en && (state != CLEAR);
    assign sweep_adv = !i_write_en;

    // Sweep write stage: decide whether the held entry is aged or expired.
    always_comb begin
        sw_we   = 1'b0;
        sw_data = s1_data;
        ageout  = 1'b0;
        if (state == SWEEP && sweep_adv && s1_valid && s1_data.valid) begin
            sw_we = 1'b1;
            if (s1_data.age <= pTIME'(1)) begin
                sw_data.valid = 1'b0;
                sw_data.age   = '0;
                ageout        = 1'b1;
            end else begin
                sw_data.age = s1_data.age - 1'b1;
            end
        end
    end

    // Storage write port: clear, learn and sweep write are mutually exclusive.
    always_ff @(posedge iclk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (learn) begin
            mem[i_write_sa] <= '{valid: 1'b1, port: i_write_port, age: pTIME'(pAGE_INIT)};
        end else if (sw_we) begin
            mem[s1_addr] <= sw_data;
        end
    end

    // Table controller: clear walk, idle, and the stallable sweep pipeline.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            sweep_ptr <= '0;
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_valid  <= 1'b0;
            rd_done   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    pending <= 1'b0;
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == AW'(pSLOTS - 1)) begin
                        clr_ptr <= '0;
                        state   <= IDLE;
                    end
                end
                IDLE: begin
                    if (tick) begin
                        state     <= SWEEP;
                        sweep_ptr <= '0;
                        rd_done   <= 1'b0;
                        s1_valid  <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    if (!sweep_adv) begin
                        // Learn this cycle: hold everything, drop a now-stale write.
                        if (s1_valid && i_write_sa == s1_addr) begin
                            s1_valid <= 1'b0;
                        end
                    end else if (!rd_done) begin
                        s1_valid  <= 1'b1;
                        s1_addr   <= sweep_ptr;
                        s1_data   <= mem[sweep_ptr];
                        sweep_ptr <= sweep_ptr + 1'b1;
                        if (sweep_ptr == AW'(pSLOTS - 1)) begin
                            rd_done <= 1'b1;
                        end
                    end else begin
                        s1_valid <= 1'b0;
                        if (pending || tick) begin
                            pending   <= 1'b0;
                            sweep_ptr <= '0;
                            rd_done   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Lookup port: registered read of the pre-write contents.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            o_lookup_valid <= 1'b0;
            o_hit          <= 1'b0;
            o_port_num     <= '0;
        end else begin
            o_lookup_valid <= i_lookup_en;
            if (i_lookup_en && state != CLEAR && mem[i_lookup_da].valid) begin
                o_hit      <= 1'b1;
                o_port_num <= mem[i_lookup_da].port;
            end else begin
                o_hit      <= 1'b0;
                o_port_num <= '0;
            end
        end
    end

    assign o_ready      = (state != CLEAR);
    assign o_sweep_busy = (state == SWEEP);
    assign o_state      = state;

`ifdef MAC_TABLE_STATS_EN
    logic [AW:0] entry_count;

    // Valid-entry counter: new learns add, age-outs subtract.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            entry_count <= '0;
        end else if (state == CLEAR) begin
            entry_count <= '0;
        end else begin
            case ({learn && !mem[i_write_sa].valid, ageout})
                2'b10:   entry_count <= entry_count + 1'b1;
                2'b01:   entry_count <= entry_count - 1'b1;
                default: entry_count <= entry_count;
            endcase
        end
    end

    assign o_entry_count = entry_count;
`endif

endmodule

// File: tb/tb_mac_aging_table.sv
// Self-checking bench for mac_aging_table (pSLOTS=16, pONE_SECOND=64,
// pAGE_INIT=3). Lookup results flow through an expected queue; table-driven
// vectors cover learn/lookup basics, hand sequences cover aging, the
// learn-vs-sweep collision and reset mid-sweep.
module tb_mac_aging_table;
    import mac_pkg::*;

    localparam int SLOTS = 16;
    localparam int AW    = 4;

    logic           clk;
    logic           rst_n;
    logic           write_en;
    logic [AW-1:0]  write_sa;
    logic [1:0]     write_port;
    logic           lookup_en;
    logic [AW-1:0]  lookup_da;
    logic           lookup_valid;
    logic           hit;
    logic [1:0]     port_num;
    logic           ready;
    logic           sweep_busy;
    logic [AW:0]    entry_count;
    mac_tbl_state_t state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic          learn;
        logic [AW-1:0] sa;
        logic [1:0]    port;
        logic          lookup;
        logic [AW-1:0] da;
        logic          exp_hit;
        logic [1:0]    exp_port;
    } vec_t;

    vec_t vecs[11];

    mac_aging_table #(
        .pSLOTS     (SLOTS),
        .pAGE_INIT  (3),
        .pONE_SECOND(64)
    ) dut (
        .iclk          (clk),
        .irst_n        (rst_n),
        .i_write_en    (write_en),
        .i_write_sa    (write_sa),
        .i_write_port  (write_port),
        .i_lookup_en   (lookup_en),
        .i_lookup_da   (lookup_da),
        .o_lookup_valid(lookup_valid),
        .o_hit         (hit),
        .o_port_num    (port_num),
        .o_ready       (ready),
        .o_sweep_busy  (sweep_busy),
`ifdef MAC_TABLE_STATS_EN
        .o_entry_count (entry_count),
`endif
        .o_state       (state_dbg)
    );

`ifndef MAC_TABLE_STATS_EN
    assign entry_count = '0;
`endif

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every lookup result is compared against the queue head.
    always @(posedge clk) begin
        #1;
        if (lookup_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lookup_unexpected: got valid result %b/%0d, expected none", hit, port_num);
            end else begin
                check("lookup", {29'd0, hit, port_num}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks (all start and end on a falling edge)
    task automatic drive_cycle(input logic we, input logic [AW-1:0] sa, input logic [1:0] port,
                               input logic le, input logic [AW-1:0] da,
                               input logic exp_hit, input logic [1:0] exp_port);
        write_en   = we;
        write_sa   = sa;
        write_port = port;
        lookup_en  = le;
        lookup_da  = da;
        if (le) exp_q.push_back({exp_hit, exp_port});
        @(negedge clk);
        write_en  = 1'b0;
        lookup_en = 1'b0;
    endtask

    task automatic learn(input logic [AW-1:0] sa, input logic [1:0] port);
        drive_cycle(1'b1, sa, port, 1'b0, '0, 1'b0, 2'd0);
    endtask

    task automatic lookup(input logic [AW-1:0] da, input logic exp_hit, input logic [1:0] exp_port);
        drive_cycle(1'b0, '0, 2'd0, 1'b1, da, exp_hit, exp_port);
    endtask

    task automatic wait_busy(input logic level, input int bound, output int cycles);
        cycles = 0;
        while (sweep_busy !== level && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
        n_tests++;
        if (sweep_busy !== level) begin
            n_fail++;
            $display("FAIL sweep_busy_wait: got busy=%b, expected %b within %0d cycles", sweep_busy, level, bound);
        end
    endtask

    task automatic wait_sweep(output int dur);
        int c;
        wait_busy(1'b1, 200, c);
        wait_busy(1'b0, 100, dur);
    endtask

    task automatic check_count(input string name, input int exp);
`ifdef MAC_TABLE_STATS_EN
        check(name, 32'(entry_count), 32'(exp));
`endif
    endtask

    task automatic count_to_ready(input int start, output int n);
        n = start;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_busy"}, 32'(sweep_busy), 32'd0);
        check({tag, "_lookup_valid"}, 32'(lookup_valid), 32'd0);
        check({tag, "_hit"}, 32'(hit), 32'd0);
        check({tag, "_port"}, 32'(port_num), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(CLEAR));
        check_count({tag, "_count"}, 0);
    endtask

    initial begin
        int n;
        int d;
        int d_norm;
        int d_stall;

        rst_n      = 1'b0;
        write_en   = 1'b0;
        write_sa   = '0;
        write_port = '0;
        lookup_en  = 1'b0;
        lookup_da  = '0;

        // Vector table: learn/lookup basics, same-cycle read-before-write, boundary slots
        vecs[0]  = '{1'b1, 4'd5,  2'd2, 1'b0, 4'd0,  1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd5,  1'b1, 2'd2};
        vecs[2]  = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd6,  1'b0, 2'd0};
        vecs[3]  = '{1'b1, 4'd3,  2'd1, 1'b1, 4'd3,  1'b0, 2'd0};
        vecs[4]  = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd3,  1'b1, 2'd1};
        vecs[5]  = '{1'b1, 4'd5,  2'd3, 1'b1, 4'd5,  1'b1, 2'd2};
        vecs[6]  = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd5,  1'b1, 2'd3};
        vecs[7]  = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd7,  1'b0, 2'd0};
        vecs[8]  = '{1'b1, 4'd15, 2'd1, 1'b0, 4'd0,  1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd15, 1'b1, 2'd1};
        vecs[10] = '{1'b0, 4'd0,  2'd0, 1'b1, 4'd0,  1'b0, 2'd0};

        // Reset state, then CLEAR length with a lookup and a dropped learn
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        drive_cycle(1'b1, 4'd6, 2'd1, 1'b1, 4'd5, 1'b0, 2'd0);
        check("clear_ready_low", 32'(ready), 32'd0);
        count_to_ready(1, n);
        check("clear_cycles", 32'(n), 32'd16);

        // Aging: learn 7, alive after ticks 1 and 2, gone after tick 3
        learn(4'd7, 2'd1);
        check_count("count_after_learn7", 1);
        lookup(4'd7, 1'b1, 2'd1);
        wait_sweep(d);
        lookup(4'd7, 1'b1, 2'd1);
        wait_sweep(d);
        lookup(4'd7, 1'b1, 2'd1);
        wait_sweep(d);
        lookup(4'd7, 1'b0, 2'd0);
        check_count("count_after_ageout7", 0);

        // Table-driven learn/lookup vectors
        for (int i = 0; i < 11; i++) begin
            drive_cycle(vecs[i].learn, vecs[i].sa, vecs[i].port, vecs[i].lookup,
                        vecs[i].da, vecs[i].exp_hit, vecs[i].exp_port);
        end
        @(negedge clk);
        check_count("count_after_table", 3);

        // Learn vs sweep collision on slot 9 holding age 1
        learn(4'd9, 2'd2);
        check_count("count_after_learn9", 4);
        wait_sweep(d_norm);
        lookup(4'd9, 1'b1, 2'd2);
        wait_sweep(d);
        check("sweep_len_stable", 32'(d), 32'(d_norm));
        lookup(4'd9, 1'b1, 2'd2);
        wait_busy(1'b1, 200, d);
        repeat (10) @(negedge clk);
        learn(4'd9, 2'd3);
        wait_busy(1'b0, 100, d);
        d_stall = 11 + d;
        check("sweep_stall_one_cycle", 32'(d_stall), 32'(d_norm + 1));
        lookup(4'd9, 1'b1, 2'd3);
        check_count("count_after_collision", 1);
        wait_sweep(d);
        lookup(4'd9, 1'b1, 2'd3);
        wait_sweep(d);
        lookup(4'd9, 1'b1, 2'd3);
        wait_sweep(d);
        lookup(4'd9, 1'b0, 2'd0);
        check_count("count_after_ageout9", 0);

        // Refill, then reset in the middle of a sweep
        learn(4'd3, 2'd1);
        learn(4'd9, 2'd2);
        learn(4'd12, 2'd3);
        lookup(4'd12, 1'b1, 2'd3);
        wait_busy(1'b1, 200, d);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsweep_reset");
        @(negedge clk);
        rst_n = 1'b1;
        count_to_ready(0, n);
        check("reclear_cycles", 32'(n), 32'd16);
        lookup(4'd3, 1'b0, 2'd0);
        lookup(4'd9, 1'b0, 2'd0);
        lookup(4'd12, 1'b0, 2'd0);
        lookup(4'd0, 1'b0, 2'd0);
        lookup(4'd15, 1'b0, 2'd0);
        check_count("count_after_reclear", 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
